stream_fifo: RTL and testbench

Synchronous single-clock FIFO with a valid/ready handshake on both sides, parametrised in data width and depth. It adds an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and a choice of first-word-fall-through or registered-read output. It is the general-purpose buffering element between peripheral datapaths (UART, SPI, GPIO capture) and the bus-side register interface.

---
 rtl/stream_fifo.sv | 126 ++++++++++++
 tb/tb_stream_fifo.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// Single-clock valid/ready FIFO with occupancy count, almost flags,
// synchronous flush and selectable fall-through or registered read port.
module stream_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter int FWFT       = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);
    localparam logic [PW-1:0] AE_LVL = PW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;

    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic          push;
    logic          pop;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Wrap bit distinguishes full from empty when the indices coincide.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign in_ready     = !full;
    assign push         = in_valid && in_ready;
    assign count        = count_q;
    assign almost_full  = (count_q >= AF_LVL);
    assign almost_empty = (count_q <= AE_LVL);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + PW'(1);
                2'b01:   count_d = count_q - PW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_q[wr_idx] <= in_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign out_valid = !empty;
        assign out_data  = mem_q[rd_idx];
        assign pop       = out_valid && out_ready;
    end else begin : g_reg
        logic                  out_valid_q, out_valid_d;
        logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

        assign pop = out_ready && !empty;

        always_comb begin
            out_valid_d = pop && !clear;
            out_data_d  = out_data_q;
            if (pop && !clear) begin
                out_data_d = mem_q[rd_idx];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else begin
                out_valid_q <= out_valid_d;
                out_data_q  <= out_data_d;
            end
        end

        assign out_valid = out_valid_q;
        assign out_data  = out_data_q;
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo: fall-through and registered-read builds side by
// side, checked every cycle against a queue-based reference model.
module tb_stream_fifo;

    logic       clk;
    logic       reset_n;
    logic       clear;
    logic       in_valid;
    logic [7:0] in_data;
    logic       out_ready;

    logic       a_in_ready, a_out_valid, a_full, a_empty, a_af, a_ae;
    logic [7:0] a_out_data;
    logic [4:0] a_count;
    logic       b_in_ready, b_out_valid, b_full, b_empty, b_af, b_ae;
    logic [7:0] b_out_data;
    logic [4:0] b_count;

    int checks;
    int failures;

    logic [7:0] mq [$];
    logic       m_rvalid;
    logic [7:0] m_rdata;

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .count(a_count), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae)
    );

    stream_fifo #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_reg (
        .clk(clk), .reset_n(reset_n), .clear(clear),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_data(b_out_data), .count(b_count), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: compare at the falling edge, advance the model at the rise.
    task automatic tick();
        int         sz;
        logic [10:0] exp_a, exp_b, got_a, got_b;
        logic       do_push, do_pop;
        @(negedge clk);
        sz = mq.size();
        exp_a = {sz < 16, sz == 16, sz == 0, sz >= 14, sz <= 2, sz > 0, 5'(sz)};
        exp_b = {sz < 16, sz == 16, sz == 0, sz >= 14, sz <= 2, m_rvalid, 5'(sz)};
        got_a = {a_in_ready, a_full, a_empty, a_af, a_ae, a_out_valid, a_count};
        got_b = {b_in_ready, b_full, b_empty, b_af, b_ae, b_out_valid, b_count};
        checks++;
        if (got_a !== exp_a) begin
            failures++;
            $display("FAIL fwft_status t=%0t got=%h exp=%h", $time, got_a, exp_a);
        end
        checks++;
        if (got_b !== exp_b) begin
            failures++;
            $display("FAIL reg_status t=%0t got=%h exp=%h", $time, got_b, exp_b);
        end
        if (sz > 0) begin
            checks++;
            if (a_out_data !== mq[0]) begin
                failures++;
                $display("FAIL fwft_data t=%0t got=%h exp=%h", $time, a_out_data, mq[0]);
            end
        end
        checks++;
        if (b_out_data !== m_rdata) begin
            failures++;
            $display("FAIL reg_data t=%0t got=%h exp=%h", $time, b_out_data, m_rdata);
        end
        do_push = in_valid && (sz < 16);
        do_pop  = out_ready && (sz > 0);
        @(posedge clk);
        if (clear) begin
            mq.delete();
            m_rvalid = 1'b0;
        end else begin
            m_rvalid = do_pop;
            if (do_pop) m_rdata = mq.pop_front();
            if (do_push) mq.push_back(in_data);
        end
        #1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_rvalid = 1'b0;
        m_rdata  = 8'h00;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_n = 1'b0;
        model_reset();
        #12;
        checks++;
        if ({a_empty, a_full, a_in_ready, a_ae, a_af, a_out_valid, a_count} !== 11'b10110_0_00000) begin
            failures++;
            $display("FAIL reset_fwft got e=%b f=%b r=%b ae=%b af=%b v=%b c=%0d exp 1 0 1 1 0 0 0",
                     a_empty, a_full, a_in_ready, a_ae, a_af, a_out_valid, a_count);
        end
        checks++;
        if ({b_out_valid, b_out_data, b_count, b_empty} !== {1'b0, 8'h00, 5'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_reg got v=%b d=%h c=%0d e=%b exp 0 00 0 1",
                     b_out_valid, b_out_data, b_count, b_empty);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        tick();
    endtask

    task automatic test_fill_drain();
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            tick();
            checks++;
            if (a_count !== 5'(i + 1) || a_af !== (i + 1 >= 14)) begin
                failures++;
                $display("FAIL fill_count got c=%0d af=%b exp c=%0d af=%b",
                         a_count, a_af, i + 1, (i + 1 >= 14));
            end
        end
        in_data = 8'hAA;
        tick();
        checks++;
        if (a_count !== 5'd16 || a_in_ready !== 1'b0 || a_full !== 1'b1) begin
            failures++;
            $display("FAIL overflow got c=%0d r=%b f=%b exp 16 0 1", a_count, a_in_ready, a_full);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (a_count !== 5'd15 || b_out_data !== 8'h00) begin
            failures++;
            $display("FAIL full_pop got c=%0d d=%h exp 15 00", a_count, b_out_data);
        end
        out_ready = 1'b0;
        tick();
        checks++;
        if (a_count !== 5'd16) begin
            failures++;
            $display("FAIL full_repush got c=%0d exp 16", a_count);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) tick();
        checks++;
        if (a_empty !== 1'b1 || b_out_data !== 8'hAA) begin
            failures++;
            $display("FAIL drain_end got e=%b d=%h exp 1 aa", a_empty, b_out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hF0 + 8'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            in_data = 8'h10 + 8'(i);
            tick();
            checks++;
            if (a_count !== 5'd4) begin
                failures++;
                $display("FAIL stream_count got c=%0d exp 4", a_count);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        out_ready = 1'b0;
    endtask

    task automatic test_registered_read();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (b_out_valid !== 1'b1 || b_out_data !== 8'h5A) begin
            failures++;
            $display("FAIL reg_read got v=%b d=%h exp 1 5a", b_out_valid, b_out_data);
        end
        tick();
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== 8'h5A || b_empty !== 1'b1) begin
            failures++;
            $display("FAIL reg_empty_read got v=%b d=%h e=%b exp 0 5a 1", b_out_valid, b_out_data, b_empty);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h30 + 8'(i);
            tick();
        end
        clear   = 1'b1;
        in_data = 8'h77;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (a_count !== 5'd0 || a_empty !== 1'b1 || b_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL clear got c=%0d e=%b v=%b exp 0 1 0", a_count, a_empty, b_out_valid);
        end
        in_valid = 1'b1;
        in_data  = 8'h40;
        tick();
        in_data = 8'h41;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (b_out_data !== 8'h40) begin
            failures++;
            $display("FAIL clear_first got d=%h exp 40", b_out_data);
        end
        tick();
        tick();
        checks++;
        if (a_empty !== 1'b1 || b_out_data !== 8'h41) begin
            failures++;
            $display("FAIL clear_drain got e=%b d=%h exp 1 41", a_empty, b_out_data);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 60);
            out_ready = ($urandom_range(0, 99) < (i < 200 ? 35 : 70));
            clear     = ($urandom_range(0, 99) < 2);
            in_data   = 8'($urandom);
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'hC0 + 8'(i);
            tick();
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (a_count !== 5'd0 || a_empty !== 1'b1 || b_out_valid !== 1'b0 || b_out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid got c=%0d e=%b v=%b d=%h exp 0 1 0 00",
                     a_count, a_empty, b_out_valid, b_out_data);
        end
        idle_inputs();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h99;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        idle_inputs();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        idle_inputs();
        model_reset();
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_registered_read();
        test_clear();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
